rrarb4_ctrl: RTL and testbench

Round-robin arbiter and sequencer for one shared resource with four requesters, built in the mcu7t5v0 library flavour. It samples four request lines and issues one registered one-hot grant at a time. Each grant is held until the owner signals completion, drops its request, or a hold-time limit expires. A combinational `NOREQ` flag (4-input NOR of the requests) lets downstream logic gate the resource off when nobody wants it.

---
 rtl/rrarb4_pkg.sv | 21 ++
 rtl/rrarb4_pick.sv | 27 ++
 rtl/rrarb4_ctrl.sv | 87 ++++++++
 tb/tb_rrarb4_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rrarb4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Holds the FSM state encoding, the requester count and the one-hot decoder.
package rrarb4_pkg;

    localparam int N_REQ = 4;
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] code;
        code      = '0;
        code[idx] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/rrarb4_pick.sv
// Combinational rotating-priority encoder.
// The search starts at ptr and wraps modulo 4.
module rrarb4_pick
    import rrarb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        // Walk from lowest to highest priority so that the closest hit to ptr is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + PTR_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rrarb4_ctrl.sv
// Round-robin arbiter/sequencer for one shared resource with four requesters.
// Holds a registered one-hot grant until DONE, a request drop, or hold-time expiry.
module rrarb4_ctrl
    import rrarb4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic             GNT_VLD,
    output logic             TIMEOUT,
    output logic             NOREQ
);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [HOLD_W-1:0] hold_cnt;

    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_limit;
    logic              req_drop;
    logic              rel;

    rrarb4_pick u_pick (
        .req (REQ),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign NOREQ      = ~(REQ[0] | REQ[1] | REQ[2] | REQ[3]);
    assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign req_drop   = ~REQ[owner];
    assign rel        = DONE | req_drop | hold_limit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            GNT      <= '0;
            GNT_VLD  <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        GNT      <= onehot4(pick_idx);
                        GNT_VLD  <= 1'b1;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        GNT     <= '0;
                        GNT_VLD <= 1'b0;
                        ptr     <= owner + PTR_W'(1);
                        // Only a pure hold-time expiry counts as a forced release.
                        TIMEOUT <= hold_limit & ~DONE & ~req_drop;
                        state   <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    GNT     <= '0;
                    GNT_VLD <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rrarb4_ctrl.sv
// Directed testbench for rrarb4_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rrarb4_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DONE;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       GNT_VLD;
    logic       TIMEOUT;
    logic       NOREQ;

    int tests = 0;
    int fails = 0;

    rrarb4_ctrl #(.MAX_HOLD(16)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_VLD (GNT_VLD),
        .TIMEOUT (TIMEOUT),
        .NOREQ   (NOREQ)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 4'b0000; DONE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL reset_gnt c%0d: got %b want 0000", i, GNT); end
            tests++; if (GNT_VLD !== 1'b0) begin fails++; $display("FAIL reset_vld c%0d: got %b want 0", i, GNT_VLD); end
            tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL reset_to c%0d: got %b want 0", i, TIMEOUT); end
            tests++; if (NOREQ !== 1'b1) begin fails++; $display("FAIL reset_noreq c%0d: got %b want 1", i, NOREQ); end
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL idle_gnt c%0d: got %b want 0000", i, GNT); end
            tests++; if (GNT_VLD !== 1'b0) begin fails++; $display("FAIL idle_vld c%0d: got %b want 0", i, GNT_VLD); end
            tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL idle_to c%0d: got %b want 0", i, TIMEOUT); end
            tests++; if (NOREQ !== 1'b1) begin fails++; $display("FAIL idle_noreq c%0d: got %b want 1", i, NOREQ); end
        end
        REQ = 4'b0100;
        #1;
        tests++; if (NOREQ !== 1'b0) begin fails++; $display("FAIL noreq_comb: got %b want 0", NOREQ); end
        REQ = 4'b0000;
        #1;
        tests++; if (NOREQ !== 1'b1) begin fails++; $display("FAIL noreq_back: got %b want 1", NOREQ); end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL noreq_nogrant: got %b want 0000", GNT); end
    endtask

    // ptr = 0 on entry; leaves ptr = 1 in IDLE.
    task automatic test_rotation();
        logic [3:0] seq [0:4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (GNT !== seq[k]) begin fails++; $display("FAIL rot_gnt%0d: got %b want %b", k, GNT, seq[k]); end
            tests++; if (GNT_VLD !== 1'b1) begin fails++; $display("FAIL rot_vld%0d: got %b want 1", k, GNT_VLD); end
            tick();
            tick();
            tests++; if (GNT !== seq[k]) begin fails++; $display("FAIL rot_hold%0d: got %b want %b", k, GNT, seq[k]); end
            if (k == 4) REQ = 4'b0000;
            else DONE = 1'b1;
            tick();
            DONE = 1'b0;
            tests++; if (GNT_VLD !== 1'b0) begin fails++; $display("FAIL rot_rel%0d: got %b want 0", k, GNT_VLD); end
            tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL rot_to%0d: got %b want 0", k, TIMEOUT); end
            tick();
            tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL rot_gap%0d: got %b want 0000", k, GNT); end
        end
    endtask

    // ptr = 1 on entry; leaves ptr = 2 in IDLE.
    task automatic test_timeout();
        REQ = 4'b0010;
        tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL to_first: got %b want 0010", GNT); end
        for (int i = 1; i < 16; i++) begin
            tick();
            tests++; if (GNT !== 4'b0010 || TIMEOUT !== 1'b0) begin
                fails++; $display("FAIL to_hold c%0d: got gnt=%b to=%b want gnt=0010 to=0", i, GNT, TIMEOUT);
            end
        end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL to_drop: got %b want 0000", GNT); end
        tests++; if (TIMEOUT !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", TIMEOUT); end
        tick();
        tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL to_pulse_end: got %b want 0", TIMEOUT); end
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL to_gap: got %b want 0000", GNT); end
        tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL to_regrant: got %b want 0010", GNT); end
        REQ = 4'b0000;
        tick();
        tests++; if (GNT !== 4'b0000 || TIMEOUT !== 1'b0) begin
            fails++; $display("FAIL to_reqdrop: got gnt=%b to=%b want gnt=0000 to=0", GNT, TIMEOUT);
        end
        tick();
    endtask

    // ptr = 2 on entry; leaves ptr = 0 in IDLE.
    task automatic test_req_drop();
        REQ = 4'b1101;
        tick();
        tests++; if (GNT !== 4'b0100) begin fails++; $display("FAIL drop_own: got %b want 0100", GNT); end
        tick();
        REQ = 4'b1001;
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL drop_clear: got %b want 0000", GNT); end
        tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL drop_to: got %b want 0", TIMEOUT); end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL drop_gap: got %b want 0000", GNT); end
        tick();
        tests++; if (GNT !== 4'b1000) begin fails++; $display("FAIL drop_next: got %b want 1000", GNT); end
        DONE = 1'b1;
        tick();
        DONE = 1'b0; REQ = 4'b0000;
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL drop_done: got %b want 0000", GNT); end
        tick();
        tick();
    endtask

    // ptr = 0 on entry; leaves ptr = 2 in IDLE.
    task automatic test_simultaneous();
        REQ = 4'b0010;
        tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL simA_own: got %b want 0010", GNT); end
        for (int i = 0; i < 15; i++) tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL simA_last: got %b want 0010", GNT); end
        DONE = 1'b1;
        tick();
        DONE = 1'b0; REQ = 4'b0000;
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL simA_rel: got %b want 0000", GNT); end
        tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL simA_to: got %b want 0", TIMEOUT); end
        tick();
        tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL simA_to2: got %b want 0", TIMEOUT); end
        tick();

        REQ = 4'b1010;
        tick();
        tests++; if (GNT !== 4'b1000) begin fails++; $display("FAIL simB_own: got %b want 1000", GNT); end
        tick();
        RST = 1'b1;
        #1;
        tests++; if (NOREQ !== 1'b0) begin fails++; $display("FAIL simB_noreq: got %b want 0", NOREQ); end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL simB_rst_gnt: got %b want 0000", GNT); end
        tests++; if (GNT_VLD !== 1'b0) begin fails++; $display("FAIL simB_rst_vld: got %b want 0", GNT_VLD); end
        tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL simB_rst_to: got %b want 0", TIMEOUT); end
        RST = 1'b0;
        tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL simB_after: got %b want 0010", GNT); end
        DONE = 1'b1;
        tick();
        DONE = 1'b0; REQ = 4'b0000;
        tick();
        tick();
    endtask

    // ptr = 2 on entry.
    task automatic test_ignored_done();
        DONE = 1'b1;
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL ign_idle: got %b want 0000", GNT); end
        DONE = 1'b0; REQ = 4'b1111;
        tick();
        tests++; if (GNT !== 4'b0100) begin fails++; $display("FAIL ign_grant: got %b want 0100", GNT); end
        DONE = 1'b1;
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL ign_rel: got %b want 0000", GNT); end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL ign_gap: got %b want 0000", GNT); end
        tick();
        tests++; if (GNT !== 4'b1000) begin fails++; $display("FAIL ign_next: got %b want 1000", GNT); end
        DONE = 1'b0; REQ = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_simultaneous();
        test_ignored_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
